// File: rtl/student_fir_tap_engine.sv
// ---------------------------------------------------------------------------
// student_fir_tap_engine
//
// Sequential single-MAC FIR engine. It sits directly downstream of the
// coefficient dual-port RAM and reads taps through that RAM's read port.
//
// For every accepted input sample x[n] the engine computes
//     y[n] = sum_{k=0}^{NumTaps-1} h[k] * x[n-k]
// with one multiply-accumulate per clock. It then presents the
// full-precision result on a valid/ready output.
//
// Sample history is kept in an internal circular buffer of depth
// 2**AddrWidth. The buffer is never cleared. A fill counter masks entries
// that have not been written since reset, so those entries contribute zero.
//
// Timeline for one output (cycle 0 = accept):
//     cycle 0              : sample accepted, written into history
//     cycles 1..NumTaps    : RUN, coefficient read k issued, history tap registered
//     cycle NumTaps+1      : DRAIN, last accumulate
//     cycle NumTaps+2..    : DONE, result_valid_o high until result_ready_i
//
// Ports
//     clk_i           clock, rising edge
//     rst_ni          asynchronous active-low reset
//     sample_i        signed input sample
//     sample_valid_i  sample_i valid
//     sample_ready_o  engine can accept a sample (IDLE only)
//     enb_o           coefficient RAM read enable
//     addrb_o         coefficient RAM read address (tap index k)
//     dob_i           coefficient RAM read data, valid 1 cycle after enb_o
//     result_o        signed y[n], stable while result_valid_o is high
//     result_valid_o  result_o valid
//     result_ready_i  downstream accepts the result
//     busy_o          engine not idle
// ---------------------------------------------------------------------------
module student_fir_tap_engine #(
    parameter int AddrWidth      = 10,
    parameter int NumTaps        = 1024,
    parameter int CoeffDataSize  = 16,
    parameter int SampleDataSize = 16,
    parameter int AccWidth       = SampleDataSize + CoeffDataSize + AddrWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [SampleDataSize-1:0] sample_i,
    input  logic                      sample_valid_i,
    output logic                      sample_ready_o,
    output logic                      enb_o,
    output logic [AddrWidth-1:0]      addrb_o,
    input  logic [CoeffDataSize-1:0]  dob_i,
    output logic [AccWidth-1:0]       result_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      busy_o
);

    localparam int Depth     = 2 ** AddrWidth;
    localparam int FillWidth = AddrWidth + 1;
    localparam int ProdWidth = SampleDataSize + CoeffDataSize;
    localparam int ExtWidth  = AccWidth - ProdWidth;

    localparam logic [FillWidth-1:0] FillMax = FillWidth'(NumTaps);
    localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(NumTaps - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [AddrWidth-1:0]        wptr_q, wptr_d;
    logic [AddrWidth-1:0]        base_q, base_d;
    logic [AddrWidth-1:0]        k_q, k_d;
    logic [FillWidth-1:0]        fill_q, fill_d;
    logic [AccWidth-1:0]         acc_q, acc_d;
    logic [SampleDataSize-1:0]   tap_sample_q, tap_sample_d;
    logic                        mac_en_q, mac_en_d;

    // History buffer. It has no reset because the fill count masks stale entries.
    logic [SampleDataSize-1:0]   hist_mem [Depth];
    logic                        hist_we;
    logic [AddrWidth-1:0]        hist_rd_addr;
    logic [SampleDataSize-1:0]   hist_rd_data;

    logic signed [ProdWidth-1:0] coeff_ext;
    logic signed [ProdWidth-1:0] sample_ext;
    logic signed [ProdWidth-1:0] product;
    logic [AccWidth-1:0]         product_ext;

    // Tap k of the current output lives k entries behind the newest sample.
    // The subtraction wraps naturally in AddrWidth bits.
    assign hist_rd_addr = base_q - k_q;
    assign hist_rd_data = hist_mem[hist_rd_addr];

    // Both operands are sign-extended to the full product width before multiplying,
    // so the product is exact. It is then sign-extended into the accumulator width.
    always_comb begin
        coeff_ext   = {{SampleDataSize{dob_i[CoeffDataSize-1]}}, dob_i};
        sample_ext  = {{CoeffDataSize{tap_sample_q[SampleDataSize-1]}}, tap_sample_q};
        product     = coeff_ext * sample_ext;
        product_ext = {{ExtWidth{product[ProdWidth-1]}}, product};
    end

    // Next-state and datapath control.
    // The MAC runs one cycle behind each RUN issue, driven by mac_en_q. That
    // timing lines the registered history tap up with the RAM's 1-cycle read data.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        base_d       = base_q;
        k_d          = k_q;
        fill_d       = fill_q;
        acc_d        = acc_q;
        tap_sample_d = tap_sample_q;
        mac_en_d     = 1'b0;
        hist_we      = 1'b0;
        enb_o        = 1'b0;

        if (mac_en_q) begin
            acc_d = acc_q + product_ext;
        end

        unique case (state_q)
            StIdle: begin
                if (sample_valid_i) begin
                    hist_we = 1'b1;
                    base_d  = wptr_q;
                    wptr_d  = wptr_q + 1'b1;
                    fill_d  = (fill_q >= FillMax) ? FillMax : fill_q + 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                enb_o    = 1'b1;
                mac_en_d = 1'b1;
                // Taps reaching back past the samples written since reset count as zero.
                tap_sample_d = ({1'b0, k_q} < fill_q) ? hist_rd_data : '0;
                k_d      = k_q + 1'b1;
                if (k_q == LastTap) begin
                    state_d = StDrain;
                end
            end

            StDrain: begin
                state_d = StDone;
            end

            StDone: begin
                if (result_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and datapath registers. Reset discards any partial result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            base_q       <= '0;
            k_q          <= '0;
            fill_q       <= '0;
            acc_q        <= '0;
            tap_sample_q <= '0;
            mac_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            base_q       <= base_d;
            k_q          <= k_d;
            fill_q       <= fill_d;
            acc_q        <= acc_d;
            tap_sample_q <= tap_sample_d;
            mac_en_q     <= mac_en_d;
        end
    end

    // History write port: the accepted sample goes into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
        if (hist_we) begin
            hist_mem[wptr_q] <= sample_i;
        end
    end

    assign sample_ready_o = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = (state_q == StDone);
    assign result_o       = acc_q;
    assign addrb_o        = enb_o ? k_q : '0;

endmodule

// File: tb/tb_student_fir_tap_engine.sv
// ---------------------------------------------------------------------------
// tb_student_fir_tap_engine
//
// Scoreboard bench for student_fir_tap_engine with NumTaps=4 and AddrWidth=2.
// A small coefficient RAM model answers enb_o/addrb_o one cycle later.
// The reference model keeps the accepted samples newest-first since reset.
// When a sample is accepted, the expected y[n] is pushed into a queue.
// A monitor pops that queue on every result handshake.
// ---------------------------------------------------------------------------
module tb_student_fir_tap_engine;

    localparam int AddrWidth = 2;
    localparam int NumTaps   = 4;
    localparam int Cw        = 16;
    localparam int Sw        = 16;
    localparam int AccW      = Sw + Cw + AddrWidth;

    logic            clk;
    logic            rst_n;
    logic [Sw-1:0]   sample_i;
    logic            sample_valid_i;
    logic            sample_ready_o;
    logic            enb_o;
    logic [AddrWidth-1:0] addrb_o;
    logic [Cw-1:0]   dob_i;
    logic [AccW-1:0] result_o;
    logic            result_valid_o;
    logic            result_ready_i;
    logic            busy_o;

    logic [Cw-1:0]   coeff [NumTaps];
    int              hist_model[$];
    longint          exp_q[$];
    longint          got_q[$];

    int              checks   = 0;
    int              failures = 0;
    logic            rand_ready  = 1'b0;
    logic            ready_force = 1'b1;

    student_fir_tap_engine #(
        .AddrWidth(AddrWidth),
        .NumTaps(NumTaps),
        .CoeffDataSize(Cw),
        .SampleDataSize(Sw),
        .AccWidth(AccW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .sample_i(sample_i),
        .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o),
        .enb_o(enb_o),
        .addrb_o(addrb_o),
        .dob_i(dob_i),
        .result_o(result_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Coefficient RAM read port, 1-cycle latency.
    initial begin
        dob_i = '0;
        forever begin
            @(posedge clk);
            if (enb_o) dob_i <= coeff[addrb_o];
        end
    end

    // Downstream ready: either forced by the test or randomised.
    initial begin
        result_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            result_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: on every result handshake, pop the scoreboard and compare.
    // While the result is held, it also checks that result_o stays stable.
    initial begin
        longint e;
        logic   have_hold;
        logic [AccW-1:0] hold_val;
        have_hold = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_hold = 1'b0;
            end else if (result_valid_o) begin
                if (have_hold) check_output("result_stable", longint'(result_o), longint'(hold_val));
                if (result_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_result: got %0d expected none", $signed(result_o));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("result", longint'($signed(result_o)), e);
                        got_q.push_back(longint'($signed(result_o)));
                    end
                    have_hold = 1'b0;
                end else begin
                    have_hold = 1'b1;
                    hold_val  = result_o;
                end
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    // Reference model: y = sum of h[k] * x[n-k] over the samples seen since reset.
    task automatic model_accept(input logic [Sw-1:0] x);
        longint e;
        hist_model.push_front(int'($signed(x)));
        if (hist_model.size() > NumTaps) void'(hist_model.pop_back());
        e = 0;
        for (int k = 0; k < hist_model.size(); k++) begin
            e += longint'($signed(coeff[k])) * longint'(hist_model[k]);
        end
        exp_q.push_back(e);
    endtask

    // Holds sample_valid_i until the engine is idle; the accept is the next rising edge.
    task automatic apply_stimulus(input logic [Sw-1:0] x);
        logic accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        sample_i       = x;
        sample_valid_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sample_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            model_accept(x);
            #1;
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1");
        end
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy_o && !result_valid_o && exp_q.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy_o, exp_q.size());
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        hist_model.delete();
        #1;
        check_output("rst_sample_ready", longint'(sample_ready_o), 1);
        check_output("rst_enb", longint'(enb_o), 0);
        check_output("rst_addrb", longint'(addrb_o), 0);
        check_output("rst_result", longint'(result_o), 0);
        check_output("rst_result_valid", longint'(result_valid_o), 0);
        check_output("rst_busy", longint'(busy_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_coeffs_ramp();
        for (int k = 0; k < NumTaps; k++) coeff[k] = Cw'(k + 1);
    endtask

    initial begin
        logic [Sw-1:0] x;
        logic          seen;
        logic [AccW-1:0] held;
        longint        impulse_exp [5];

        rst_n          = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        set_coeffs_ramp();
        reset_dut();

        // Impulse response.
        $display("[TB] impulse");
        impulse_exp = '{1, 2, 3, 4, 0};
        got_q.delete();
        apply_stimulus(16'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(16'd0);
        wait_idle();
        check_output("impulse_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) check_output("impulse_val", got_q[i], impulse_exp[i]);

        // Fill history with nonzero values, then check that reset masks them.
        apply_stimulus(16'd9);
        apply_stimulus(16'd8);
        apply_stimulus(16'd7);
        wait_idle();
        $display("[TB] fill masking");
        reset_dut();
        got_q.delete();
        apply_stimulus(16'd5);
        apply_stimulus(16'd1);
        wait_idle();
        check_output("fill_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_output("fill_first", got_q[0], 5);
            check_output("fill_second", got_q[1], 11);
        end

        // Extremes: every coefficient and sample at the negative limit.
        $display("[TB] extremes");
        for (int k = 0; k < NumTaps; k++) coeff[k] = 16'h8000;
        reset_dut();
        got_q.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(16'h8000);
        wait_idle();
        check_output("extreme_count", got_q.size(), 4);
        if (got_q.size() == 4) check_output("extreme_last", got_q[3], 64'sd4294967296);
        set_coeffs_ramp();

        // Backpressure: the result is held while ready stays low.
        $display("[TB] backpressure");
        ready_force = 1'b0;
        apply_stimulus(16'd3);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (result_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("bp_valid_seen", longint'(seen), 1);
        held = result_o;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output("bp_valid", longint'(result_valid_o), 1);
            check_output("bp_hold", longint'(result_o), longint'(held));
            check_output("bp_sample_ready", longint'(sample_ready_o), 0);
            check_output("bp_enb", longint'(enb_o), 0);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("bp_release_valid", longint'(result_valid_o), 0);
        check_output("bp_release_ready", longint'(sample_ready_o), 1);
        wait_idle();

        // Latency and coefficient read sequence.
        $display("[TB] latency");
        @(posedge clk);
        #1;
        sample_i       = 16'd2;
        sample_valid_i = 1'b1;
        @(negedge clk);
        check_output("lat_ready_c0", longint'(sample_ready_o), 1);
        @(posedge clk);
        model_accept(16'd2);
        #1;
        sample_valid_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_output("lat_enb", longint'(enb_o), (c <= 4) ? 1 : 0);
            if (c <= 4) check_output("lat_addrb", longint'(addrb_o), c - 1);
            check_output("lat_result_valid", longint'(result_valid_o), (c == 6) ? 1 : 0);
        end
        wait_idle();

        // Reset in the middle of RUN; the partial result must never appear.
        $display("[TB] reset mid-run");
        apply_stimulus(16'd6);
        reset_dut();
        got_q.delete();
        apply_stimulus(16'd7);
        wait_idle();
        check_output("midrst_count", got_q.size(), 1);
        if (got_q.size() == 1) check_output("midrst_val", got_q[0], 7);

        // Random coefficients, samples and downstream backpressure.
        $display("[TB] random");
        for (int k = 0; k < NumTaps; k++) coeff[k] = Cw'($urandom);
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = Sw'($urandom);
            apply_stimulus(x);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
            end
        end
        wait_idle();
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
